// File: rtl/pe_nlm_stream.sv
// pe_nlm_stream
//   One processing element of a systolic non-local-means denoise chain.
//   Each valid cycle it takes a reference patch, a search patch and the
//   search centre pixel. It computes the squared-difference distance
//   between the patches and maps that distance to a weight through a
//   programmable linear-clamp curve. It then adds weight*centre and weight
//   onto the pixel/weight sums passed down the chain.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ce                global enable; 0 freezes every register
//   valid_i           patch inputs valid
//   ref_blk_i         reference patch, pixel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   srh_blk_i         search patch, same packing
//   srh_ctr_i         search centre pixel
//   valid_o, ref_blk_o, srh_blk_o, srh_ctr_o
//                     pass-through to the next PE, one cycle of latency
//   cfg_thresh        distances >= cfg_thresh get weight 0
//   cfg_slope         weight falls by (D*cfg_slope) >> SLOPE_SHIFT
//   pix_sum_i, weight_sum_i
//                     sums from the previous PE (ignored when FIRST_PE=1)
//   pix_sum_o, weight_sum_o
//                     saturating accumulated sums, four cycles after valid_i
//   sum_valid_o       sums belong to a valid patch
//   clr_sat           clears the sticky saturation flag
//   sat_o             sticky flag: a sum has clamped to all-ones
module pe_nlm_stream #(
  parameter int DATA_WIDTH       = 16,
  parameter int REF_LENGTH       = 5,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int SLOPE_WIDTH      = 16,
  parameter int SLOPE_SHIFT      = 8,
  parameter int PIX_SUM_WIDTH    = 32,
  parameter int WEIGHT_SUM_WIDTH = 32,
  parameter int FIRST_PE         = 0,
  parameter int DIST_WIDTH       = 2*DATA_WIDTH + $clog2(REF_LENGTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ce,
  input  logic                             valid_i,
  input  logic [REF_LENGTH*DATA_WIDTH-1:0] ref_blk_i,
  input  logic [REF_LENGTH*DATA_WIDTH-1:0] srh_blk_i,
  input  logic [DATA_WIDTH-1:0]            srh_ctr_i,
  output logic                             valid_o,
  output logic [REF_LENGTH*DATA_WIDTH-1:0] ref_blk_o,
  output logic [REF_LENGTH*DATA_WIDTH-1:0] srh_blk_o,
  output logic [DATA_WIDTH-1:0]            srh_ctr_o,
  input  logic [DIST_WIDTH-1:0]            cfg_thresh,
  input  logic [SLOPE_WIDTH-1:0]           cfg_slope,
  input  logic [PIX_SUM_WIDTH-1:0]         pix_sum_i,
  input  logic [WEIGHT_SUM_WIDTH-1:0]      weight_sum_i,
  output logic [PIX_SUM_WIDTH-1:0]         pix_sum_o,
  output logic [WEIGHT_SUM_WIDTH-1:0]      weight_sum_o,
  output logic                             sum_valid_o,
  input  logic                             clr_sat,
  output logic                             sat_o
);

  localparam int PROD_W = DIST_WIDTH + SLOPE_WIDTH;
  // One bit wider than the larger of the sum and the addend, so the carry
  // out shows whether the result still fits the chain width.
  localparam int PIX_EXT_W = ((PIX_SUM_WIDTH > WEIGHT_WIDTH + DATA_WIDTH) ?
                              PIX_SUM_WIDTH : WEIGHT_WIDTH + DATA_WIDTH) + 1;
  localparam int WT_EXT_W  = ((WEIGHT_SUM_WIDTH > WEIGHT_WIDTH) ?
                              WEIGHT_SUM_WIDTH : WEIGHT_WIDTH) + 1;
  localparam logic [WEIGHT_WIDTH-1:0] WMAX = '1;

  // Stage registers
  logic [REF_LENGTH-1:0][DATA_WIDTH-1:0] diff_d, diff_s1;
  logic [DATA_WIDTH-1:0]                 ctr_s1, ctr_s2, ctr_s3;
  logic                                  valid_s1, valid_s2, valid_s3;
  logic [DIST_WIDTH-1:0]                 dist_d, dist_s2;
  logic [WEIGHT_WIDTH-1:0]               w_d, w_s3;

  // Combinational helpers
  logic [PROD_W-1:0]           prod, p_shift;
  logic [PIX_SUM_WIDTH-1:0]    pix_in_eff, pix_next;
  logic [WEIGHT_SUM_WIDTH-1:0] wt_in_eff, wt_next;
  logic [PIX_EXT_W-1:0]        pix_ext;
  logic [WT_EXT_W-1:0]         wt_ext;
  logic                        pix_ovf, wt_ovf;

  // Pass-through data for the next PE in the chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      ref_blk_o <= '0;
      srh_blk_o <= '0;
      srh_ctr_o <= '0;
    end else if (ce) begin
      valid_o   <= valid_i;
      ref_blk_o <= ref_blk_i;
      srh_blk_o <= srh_blk_i;
      srh_ctr_o <= srh_ctr_i;
    end
  end

  // S1: per-pixel absolute difference
  always_comb begin
    diff_d = '0;
    for (int k = 0; k < REF_LENGTH; k++) begin
      if (ref_blk_i[k*DATA_WIDTH +: DATA_WIDTH] >= srh_blk_i[k*DATA_WIDTH +: DATA_WIDTH])
        diff_d[k] = ref_blk_i[k*DATA_WIDTH +: DATA_WIDTH] - srh_blk_i[k*DATA_WIDTH +: DATA_WIDTH];
      else
        diff_d[k] = srh_blk_i[k*DATA_WIDTH +: DATA_WIDTH] - ref_blk_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // S2: sum of squares at full width
  always_comb begin
    dist_d = '0;
    for (int k = 0; k < REF_LENGTH; k++)
      dist_d = dist_d + DIST_WIDTH'(diff_s1[k]) * DIST_WIDTH'(diff_s1[k]);
  end

  // S3: linear-clamp weight curve. Bubbles are forced to weight 0 so they
  // only pass the upstream sums through.
  always_comb begin
    prod    = PROD_W'(dist_s2) * PROD_W'(cfg_slope);
    p_shift = prod >> SLOPE_SHIFT;
    w_d     = '0;
    if (valid_s2 && (dist_s2 < cfg_thresh) && (p_shift < PROD_W'(WMAX)))
      w_d = WMAX - p_shift[WEIGHT_WIDTH-1:0];
  end

  // S4: accumulate onto the chain with clamp-to-all-ones on overflow
  always_comb begin
    pix_in_eff = (FIRST_PE != 0) ? '0 : pix_sum_i;
    wt_in_eff  = (FIRST_PE != 0) ? '0 : weight_sum_i;
    pix_ext    = PIX_EXT_W'(pix_in_eff) + PIX_EXT_W'(w_s3) * PIX_EXT_W'(ctr_s3);
    wt_ext     = WT_EXT_W'(wt_in_eff) + WT_EXT_W'(w_s3);
    pix_ovf    = |pix_ext[PIX_EXT_W-1:PIX_SUM_WIDTH];
    wt_ovf     = |wt_ext[WT_EXT_W-1:WEIGHT_SUM_WIDTH];
    pix_next   = pix_ovf ? '1 : pix_ext[PIX_SUM_WIDTH-1:0];
    wt_next    = wt_ovf  ? '1 : wt_ext[WEIGHT_SUM_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_s1      <= '0;
      ctr_s1       <= '0;
      valid_s1     <= 1'b0;
      dist_s2      <= '0;
      ctr_s2       <= '0;
      valid_s2     <= 1'b0;
      w_s3         <= '0;
      ctr_s3       <= '0;
      valid_s3     <= 1'b0;
      pix_sum_o    <= '0;
      weight_sum_o <= '0;
      sum_valid_o  <= 1'b0;
    end else if (ce) begin
      diff_s1      <= diff_d;
      ctr_s1       <= srh_ctr_i;
      valid_s1     <= valid_i;
      dist_s2      <= dist_d;
      ctr_s2       <= ctr_s1;
      valid_s2     <= valid_s1;
      w_s3         <= w_d;
      ctr_s3       <= ctr_s2;
      valid_s3     <= valid_s2;
      pix_sum_o    <= pix_next;
      weight_sum_o <= wt_next;
      sum_valid_o  <= valid_s3;
    end
  end

  // Sticky saturation flag. A new overflow takes priority over a clear in
  // the same cycle. The clear is honoured even while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_o <= 1'b0;
    else if (ce && (pix_ovf || wt_ovf))
      sat_o <= 1'b1;
    else if (clr_sat)
      sat_o <= 1'b0;
  end

endmodule

// File: tb/tb_pe_nlm_stream.sv
// tb_pe_nlm_stream
//   Self-checking bench for pe_nlm_stream. The bench has three instances:
//   u_pe0 is a first PE driven directly by the bench. u_pe1 is chained
//   behind u_pe0. u_pe2 is a non-first PE whose upstream sums come from the
//   bench. Expected sums are queued when a patch is driven. A negedge
//   monitor pops and compares them whenever an instance reports
//   sum_valid_o after an enabled clock edge.
module tb_pe_nlm_stream;

  localparam int DW  = 16;
  localparam int RL  = 5;
  localparam int BW  = DW*RL;
  localparam int DSW = 2*DW + $clog2(RL) + 1;

  typedef struct {
    string           name;
    logic [BW-1:0]   ref_blk;
    logic [BW-1:0]   srh_blk;
    logic [DW-1:0]   ctr;
    logic [15:0]     slope;
    logic [DSW-1:0]  thresh;
    logic [31:0]     exp_pix;
    logic [31:0]     exp_wt;
  } vec_t;

  typedef struct {
    logic [31:0] pix;
    logic [31:0] wt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n, ce, valid_i, clr_sat;
  logic [BW-1:0]   ref_blk, srh_blk;
  logic [DW-1:0]   srh_ctr;
  logic [DSW-1:0]  cfg_thresh;
  logic [15:0]     cfg_slope;
  logic [31:0]     pix_in, wt_in;

  logic            valid_o0, valid_o1, valid_o2;
  logic [BW-1:0]   ref_o0, ref_o1, ref_o2, srh_o0, srh_o1, srh_o2;
  logic [DW-1:0]   ctr_o0, ctr_o1, ctr_o2;
  logic [31:0]     pix_o0, pix_o1, pix_o2, wt_o0, wt_o1, wt_o2;
  logic            sv_o0, sv_o1, sv_o2, sat_o0, sat_o1, sat_o2;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   sv_seen = 0;
  int   last_edge0 = 0;
  int   last_edge1 = 0;
  logic adv_q = 1'b0;
  logic hold_q = 1'b0;
  logic [31:0] snap_pix0, snap_wt0, snap_pix1, snap_wt1;
  logic        snap_sv0, snap_sv1, snap_v0;

  exp_t q0[$], q1[$], q2[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pe_nlm_stream #(.FIRST_PE(1)) u_pe0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_i(valid_i),
    .ref_blk_i(ref_blk), .srh_blk_i(srh_blk), .srh_ctr_i(srh_ctr),
    .valid_o(valid_o0), .ref_blk_o(ref_o0), .srh_blk_o(srh_o0), .srh_ctr_o(ctr_o0),
    .cfg_thresh(cfg_thresh), .cfg_slope(cfg_slope),
    .pix_sum_i(pix_in), .weight_sum_i(wt_in),
    .pix_sum_o(pix_o0), .weight_sum_o(wt_o0), .sum_valid_o(sv_o0),
    .clr_sat(clr_sat), .sat_o(sat_o0));

  pe_nlm_stream #(.FIRST_PE(0)) u_pe1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_i(valid_o0),
    .ref_blk_i(ref_o0), .srh_blk_i(srh_o0), .srh_ctr_i(ctr_o0),
    .valid_o(valid_o1), .ref_blk_o(ref_o1), .srh_blk_o(srh_o1), .srh_ctr_o(ctr_o1),
    .cfg_thresh(cfg_thresh), .cfg_slope(cfg_slope),
    .pix_sum_i(pix_o0), .weight_sum_i(wt_o0),
    .pix_sum_o(pix_o1), .weight_sum_o(wt_o1), .sum_valid_o(sv_o1),
    .clr_sat(clr_sat), .sat_o(sat_o1));

  pe_nlm_stream #(.FIRST_PE(0)) u_pe2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_i(valid_i),
    .ref_blk_i(ref_blk), .srh_blk_i(srh_blk), .srh_ctr_i(srh_ctr),
    .valid_o(valid_o2), .ref_blk_o(ref_o2), .srh_blk_o(srh_o2), .srh_ctr_o(ctr_o2),
    .cfg_thresh(cfg_thresh), .cfg_slope(cfg_slope),
    .pix_sum_i(pix_in), .weight_sum_i(wt_in),
    .pix_sum_o(pix_o2), .weight_sum_o(wt_o2), .sum_valid_o(sv_o2),
    .clr_sat(clr_sat), .sat_o(sat_o2));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rep5(input logic [DW-1:0] v);
    return {5{v}};
  endfunction

  function automatic logic [31:0] sat32(input longint unsigned x);
    return (x > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  // Reference behaviour of one PE contribution (weight*centre, weight)
  function automatic void model(input logic [BW-1:0] r, input logic [BW-1:0] s,
                                input logic [DW-1:0] c, input logic [15:0] sl,
                                input logic [DSW-1:0] th,
                                output longint unsigned pix, output longint unsigned wt);
    longint unsigned d = 0;
    longint unsigned a, b, df, p, w;
    for (int k = 0; k < RL; k++) begin
      a = 64'(r[k*DW +: DW]);
      b = 64'(s[k*DW +: DW]);
      df = (a > b) ? a - b : b - a;
      d += df * df;
    end
    p = (d * 64'(sl)) >> 8;
    w = (d >= 64'(th) || p >= 255) ? 0 : 255 - p;
    pix = w * 64'(c);
    wt  = w;
  endfunction

  task automatic pushExpected(input longint unsigned cp, input longint unsigned cw);
    exp_t e;
    e.pix = sat32(cp);              e.wt = sat32(cw);              q0.push_back(e);
    e.pix = sat32(2*cp);            e.wt = sat32(2*cw);            q1.push_back(e);
    e.pix = sat32(64'(pix_in) + cp); e.wt = sat32(64'(wt_in) + cw); q2.push_back(e);
  endtask

  task automatic drivePatch(input logic [BW-1:0] r, input logic [BW-1:0] s, input logic [DW-1:0] c);
    longint unsigned cp, cw;
    ref_blk = r; srh_blk = s; srh_ctr = c; valid_i = 1'b1;
    model(r, s, c, cfg_slope, cfg_thresh, cp, cw);
    pushExpected(cp, cw);
  endtask

  task automatic addVec(input string n, input logic [BW-1:0] r, input logic [BW-1:0] s,
                        input logic [DW-1:0] c, input logic [15:0] sl, input logic [DSW-1:0] th,
                        input logic [31:0] ep, input logic [31:0] ew);
    vec_t v;
    v.name = n; v.ref_blk = r; v.srh_blk = s; v.ctr = c;
    v.slope = sl; v.thresh = th; v.exp_pix = ep; v.exp_wt = ew;
    tbl.push_back(v);
  endtask

  // One isolated table vector, with the pass-through and valid timing of
  // both chained PEs checked along the way
  task automatic applyStimulus(input vec_t v);
    cfg_slope = v.slope; cfg_thresh = v.thresh;
    ref_blk = v.ref_blk; srh_blk = v.srh_blk; srh_ctr = v.ctr; valid_i = 1'b1;
    pushExpected(64'(v.exp_pix), 64'(v.exp_wt));
    tick();
    valid_i = 1'b0;
    checkOutput({v.name, "_valid_o0"}, 64'(valid_o0), 64'(1));
    checkOutput({v.name, "_ref_o0"}, 64'(ref_o0), 64'(v.ref_blk));
    checkOutput({v.name, "_ctr_o0"}, 64'(ctr_o0), 64'(v.ctr));
    checkOutput({v.name, "_valid_o1_early"}, 64'(valid_o1), 64'(0));
    tick();
    checkOutput({v.name, "_valid_o1"}, 64'(valid_o1), 64'(1));
    checkOutput({v.name, "_valid_o0_drop"}, 64'(valid_o0), 64'(0));
    tick();
    checkOutput({v.name, "_sv0_early"}, 64'(sv_o0), 64'(0));
    tick();
    checkOutput({v.name, "_sv0_lat4"}, 64'(sv_o0), 64'(1));
    checkOutput({v.name, "_sv1_early"}, 64'(sv_o1), 64'(0));
    tick();
    checkOutput({v.name, "_sv1_lat5"}, 64'(sv_o1), 64'(1));
    checkOutput({v.name, "_sv0_drop"}, 64'(sv_o0), 64'(0));
    tick();
    tick();
  endtask

  task automatic checkResetState(input string n);
    checkOutput({n, "_pe0_vo"},  64'(valid_o0), 64'(0));
    checkOutput({n, "_pe0_ref"}, 64'(ref_o0),   64'(0));
    checkOutput({n, "_pe0_srh"}, 64'(srh_o0),   64'(0));
    checkOutput({n, "_pe0_ctr"}, 64'(ctr_o0),   64'(0));
    checkOutput({n, "_pe0_pix"}, 64'(pix_o0),   64'(0));
    checkOutput({n, "_pe0_wt"},  64'(wt_o0),    64'(0));
    checkOutput({n, "_pe0_sv"},  64'(sv_o0),    64'(0));
    checkOutput({n, "_pe0_sat"}, 64'(sat_o0),   64'(0));
    checkOutput({n, "_pe1_vo"},  64'(valid_o1), 64'(0));
    checkOutput({n, "_pe1_pix"}, 64'(pix_o1),   64'(0));
    checkOutput({n, "_pe1_sv"},  64'(sv_o1),    64'(0));
    checkOutput({n, "_pe2_vo"},  64'(valid_o2), 64'(0));
    checkOutput({n, "_pe2_pix"}, 64'(pix_o2),   64'(0));
    checkOutput({n, "_pe2_wt"},  64'(wt_o2),    64'(0));
    checkOutput({n, "_pe2_sv"},  64'(sv_o2),    64'(0));
    checkOutput({n, "_pe2_sat"}, 64'(sat_o2),   64'(0));
  endtask

  // Records what kind of edge just happened
  always @(posedge clk) begin
    adv_q  = ce && rst_n;
    hold_q = !ce && rst_n;
    edge_cnt++;
  end

  // Scoreboard monitor and stall-hold checker
  always @(negedge clk) begin
    exp_t e;
    if (adv_q) begin
      if (sv_o0) begin
        sv_seen++;
        last_edge0 = edge_cnt;
        checkOutput("sv0_expected", 64'(q0.size() > 0), 64'(1));
        if (q0.size() > 0) begin
          e = q0.pop_front();
          checkOutput("pe0_pix", 64'(pix_o0), 64'(e.pix));
          checkOutput("pe0_wt",  64'(wt_o0),  64'(e.wt));
        end
      end
      if (sv_o1) begin
        sv_seen++;
        last_edge1 = edge_cnt;
        checkOutput("sv1_expected", 64'(q1.size() > 0), 64'(1));
        if (q1.size() > 0) begin
          e = q1.pop_front();
          checkOutput("pe1_pix", 64'(pix_o1), 64'(e.pix));
          checkOutput("pe1_wt",  64'(wt_o1),  64'(e.wt));
        end
      end
      if (sv_o2) begin
        sv_seen++;
        checkOutput("sv2_expected", 64'(q2.size() > 0), 64'(1));
        if (q2.size() > 0) begin
          e = q2.pop_front();
          checkOutput("pe2_pix", 64'(pix_o2), 64'(e.pix));
          checkOutput("pe2_wt",  64'(wt_o2),  64'(e.wt));
        end
      end
    end
    if (hold_q) begin
      checkOutput("stall_hold_pix0", 64'(pix_o0), 64'(snap_pix0));
      checkOutput("stall_hold_wt0",  64'(wt_o0),  64'(snap_wt0));
      checkOutput("stall_hold_sv0",  64'(sv_o0),  64'(snap_sv0));
      checkOutput("stall_hold_vo0",  64'(valid_o0), 64'(snap_v0));
      checkOutput("stall_hold_pix1", 64'(pix_o1), 64'(snap_pix1));
      checkOutput("stall_hold_wt1",  64'(wt_o1),  64'(snap_wt1));
      checkOutput("stall_hold_sv1",  64'(sv_o1),  64'(snap_sv1));
    end
    snap_pix0 = pix_o0; snap_wt0 = wt_o0; snap_sv0 = sv_o0; snap_v0 = valid_o0;
    snap_pix1 = pix_o1; snap_wt1 = wt_o1; snap_sv1 = sv_o1;
  end

  initial begin
    int start, sv_before;
    logic [BW-1:0] s;

    addVec("ident",        rep5(16'd1000), rep5(16'd1000), 16'd100,   16'd256,  '1,      32'd25500,    32'd255);
    addVec("diff2",        rep5(16'd1000), rep5(16'd1002), 16'd100,   16'd256,  '1,      32'd23500,    32'd235);
    addVec("thresh_eq",    rep5(16'd1000), rep5(16'd1002), 16'd100,   16'd256,  36'd20,  32'd0,        32'd0);
    addVec("thresh_above", rep5(16'd1000), rep5(16'd1002), 16'd100,   16'd256,  36'd21,  32'd23500,    32'd235);
    addVec("mixed",        {16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                           {16'd50, 16'd45, 16'd30, 16'd16, 16'd13}, 16'd7, 16'd512, '1, 32'd1085, 32'd155);
    addVec("near_wmax",    {16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                           {16'd50, 16'd45, 16'd30, 16'd16, 16'd13}, 16'd65535, 16'd1280, '1, 32'd327675, 32'd5);
    addVec("p_eq_wmax",    rep5(16'd100), {16'd100, 16'd101, 16'd102, 16'd105, 16'd115},
                           16'd500, 16'd256, '1, 32'd0, 32'd0);
    addVec("p_wmax_m1",    rep5(16'd100), {16'd100, 16'd101, 16'd102, 16'd105, 16'd115},
                           16'd500, 16'd255, '1, 32'd500, 32'd1);
    addVec("full_dist",    rep5(16'd0), rep5(16'd65535), 16'd65535, 16'd0, '1, 32'd16711425, 32'd255);
    addVec("full_dist_thr", rep5(16'd0), rep5(16'd65535), 16'd65535, 16'd0, 36'd21474181125, 32'd0, 32'd0);

    // Reset with ce low: reset must still win
    rst_n = 1'b0; ce = 1'b0; valid_i = 1'b0; clr_sat = 1'b0;
    ref_blk = '0; srh_blk = '0; srh_ctr = '0;
    cfg_slope = 16'd256; cfg_thresh = '1; pix_in = 32'd1000; wt_in = 32'd10;
    tick(); tick(); tick();
    checkResetState("reset");
    rst_n = 1'b1; ce = 1'b1;
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i]);

    $display("[TB] stalled stream");
    cfg_slope = 16'd256; cfg_thresh = '1;
    start = edge_cnt;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < RL; k++)
        s[k*DW +: DW] = 16'(1000 + i*10 + ((i + k) % 4));
      drivePatch(rep5(16'(1000 + i*10)), s, 16'(100 + i));
      if (i == 4) begin
        ce = 1'b0;
        tick(); tick(); tick();
        ce = 1'b1;
      end
      tick();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    // Without the stall the last result lands 11 edges in; the stall adds 3
    checkOutput("stream_last_sv0_edge", 64'(last_edge0 - start), 64'(11 + 3));
    checkOutput("stream_last_sv1_edge", 64'(last_edge1 - start), 64'(11 + 3 + 1));

    $display("[TB] saturation");
    cfg_slope = 16'd256; cfg_thresh = '1;
    pix_in = 32'hFFFF_FF00; wt_in = 32'd0;
    tick();
    clr_sat = 1'b1;
    drivePatch(rep5(16'd1000), rep5(16'd1000), 16'd100);
    tick();
    valid_i = 1'b0;
    tick(); tick();
    checkOutput("sat_not_yet", 64'(sat_o2), 64'(0));
    tick();
    checkOutput("sat_set_wins", 64'(sat_o2), 64'(1));
    checkOutput("sat_pe0_clear", 64'(sat_o0), 64'(0));
    clr_sat = 1'b0;
    tick(); tick(); tick();
    checkOutput("sat_sticky", 64'(sat_o2), 64'(1));
    checkOutput("sat_passthru_pix", 64'(pix_o2), 64'(32'hFFFF_FF00));
    ce = 1'b0; clr_sat = 1'b1;
    tick();
    checkOutput("sat_clear_stalled", 64'(sat_o2), 64'(0));
    ce = 1'b1; clr_sat = 1'b0;
    drivePatch(rep5(16'd1000), rep5(16'd1000), 16'd100);
    tick();
    valid_i = 1'b0;
    tick(); tick(); tick();
    checkOutput("sat_set_again", 64'(sat_o2), 64'(1));
    tick(); tick(); tick();
    pix_in = 32'd1000; wt_in = 32'd10;
    tick();

    $display("[TB] reset with patches in flight");
    drivePatch(rep5(16'd500), rep5(16'd501), 16'd9);
    tick();
    drivePatch(rep5(16'd600), rep5(16'd600), 16'd8);
    tick();
    drivePatch(rep5(16'd700), rep5(16'd703), 16'd7);
    tick();
    valid_i = 1'b0; rst_n = 1'b0;
    tick();
    checkResetState("flight_reset");
    rst_n = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    sv_before = sv_seen;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("no_stale_sv", 64'(sv_seen - sv_before), 64'(0));

    checkOutput("q0_drained", 64'(q0.size()), 64'(0));
    checkOutput("q1_drained", 64'(q1.size()), 64'(0));
    checkOutput("q2_drained", 64'(q2.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
